// File: rtl/pwm_pulse_counter.sv
// Programmable pulse generator: a WIDTH-bit counter runs over a latched period P,
// driving a pulse that is high for the first H enabled cycles of each period.
module pwm_pulse_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_mode,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic [WIDTH-1:0] i_period,
    input  logic [WIDTH-1:0] i_high,
    output logic [WIDTH-1:0] o_q,
    output logic             o_pulse,
    output logic             o_busy,
    output logic             o_tc
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic [WIDTH-1:0] high_q, high_d;
    logic             mode_q, mode_d;
    logic             pulse_q, pulse_d;

    logic             at_tc;
    logic [WIDTH:0]   q_inc;
    logic             inc_below_high;

    assign at_tc          = (q_q == period_q);
    // One extra bit keeps the increment from aliasing to zero at the top of the range.
    assign q_inc          = {1'b0, q_q} + {{WIDTH{1'b0}}, 1'b1};
    assign inc_below_high = (q_inc < {1'b0, high_q});

    always_comb begin
        state_d  = state_q;
        q_d      = q_q;
        period_d = period_q;
        high_d   = high_q;
        mode_d   = mode_q;
        pulse_d  = pulse_q;

        if (i_stop) begin
            state_d = StIdle;
            q_d     = '0;
            pulse_d = 1'b0;
        end else if (i_start) begin
            state_d  = StRun;
            q_d      = '0;
            period_d = i_period;
            high_d   = i_high;
            mode_d   = i_mode;
            pulse_d  = (i_high != '0);
        end else if ((state_q == StRun) && i_en) begin
            if (at_tc) begin
                q_d = '0;
                if (mode_q) begin
                    state_d = StIdle;
                    pulse_d = 1'b0;
                end else begin
                    pulse_d = (high_q != '0);
                end
            end else begin
                q_d     = q_inc[WIDTH-1:0];
                pulse_d = inc_below_high;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= StIdle;
            q_q      <= '0;
            period_q <= '0;
            high_q   <= '0;
            mode_q   <= 1'b0;
            pulse_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            q_q      <= q_d;
            period_q <= period_d;
            high_q   <= high_d;
            mode_q   <= mode_d;
            pulse_q  <= pulse_d;
        end
    end

    assign o_q     = q_q;
    assign o_pulse = pulse_q;
    assign o_busy  = (state_q == StRun);
    assign o_tc    = o_busy & i_en & at_tc;

endmodule
